// File: rtl/ssl_pkg.sv
// Shared state encoding and width helpers for the ssl_xcorr delay estimator.
package ssl_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        SCAN  = 2'd1,
        DONE  = 2'd2
    } ssl_state_e;

    function automatic int lag_w(input int nlag);
        return (nlag > 1) ? $clog2(nlag) : 1;
    endfunction

    function automatic int acc_w(input int nwin);
        return $clog2(nwin + 1);
    endfunction

    function automatic int fc_w(input int nwin);
        return (nwin > 1) ? $clog2(nwin) : 1;
    endfunction

endpackage

// File: rtl/ssl_corr_lane.sv
// One correlation lane: NLAG XNOR accumulators for a single channel plus the
// sequential argmax that walks them during the scan phase.
module ssl_corr_lane
    import ssl_pkg::*;
#(
    parameter int NLAG = 128,
    parameter int NWIN = 1024,
    localparam int LAGW = lag_w(NLAG),
    localparam int ACCW = acc_w(NWIN)
) (
    input  logic            clk,
    input  logic            erst,
    input  logic [NLAG-1:0] tap_i,
    input  logic            din_i,
    input  logic            acc_en_i,
    input  logic            clear_i,
    input  logic            scan_en_i,
    input  logic [LAGW-1:0] scan_idx_i,
    output logic [LAGW-1:0] best_idx_d_o
);

    logic [ACCW-1:0] acc_q [NLAG];
    logic [ACCW-1:0] bestVal_q, bestVal_d, cand;
    logic [LAGW-1:0] bestIdx_q, bestIdx_d;

    always_ff @(posedge clk or negedge erst) begin
        if (!erst) begin
            for (int l = 0; l < NLAG; l++) acc_q[l] <= '0;
        end else if (clear_i) begin
            for (int l = 0; l < NLAG; l++) acc_q[l] <= '0;
        end else if (acc_en_i) begin
            for (int l = 0; l < NLAG; l++) acc_q[l] <= acc_q[l] + ACCW'(tap_i[l] ~^ din_i);
        end
    end

    // Strict greater-than keeps the lowest lag on ties; idx 0 seeds the search.
    always_comb begin
        cand      = acc_q[scan_idx_i];
        bestVal_d = bestVal_q;
        bestIdx_d = bestIdx_q;
        if (scan_en_i && ((scan_idx_i == '0) || (cand > bestVal_q))) begin
            bestVal_d = cand;
            bestIdx_d = scan_idx_i;
        end
    end

    always_ff @(posedge clk or negedge erst) begin
        if (!erst) begin
            bestVal_q <= '0;
            bestIdx_q <= '0;
        end else begin
            bestVal_q <= bestVal_d;
            bestIdx_q <= bestIdx_d;
        end
    end

    assign best_idx_d_o = bestIdx_d;

endmodule

// File: rtl/ssl_xcorr.sv
// Frame-based 1-bit cross-correlation delay estimator: channel 0 is the
// reference, every other channel reports the lag of its correlation peak.
module ssl_xcorr
    import ssl_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int NLAG = 128,
    parameter int NWIN = 1024,
    localparam int LAGW = lag_w(NLAG),
    localparam int FCW  = fc_w(NWIN)
) (
    input  logic                     clk,
    input  logic                     erst,
    input  logic [NCH-1:0]           din,
    input  logic                     din_en,
    output logic [(NCH-1)*LAGW-1:0]  did,
    output logic                     did_valid,
    output logic                     busy,
    output logic                     ovf
);

    ssl_state_e state_q, state_d;
    logic [FCW-1:0]            frameCnt_q, frameCnt_d;
    logic [LAGW-1:0]           scanIdx_q, scanIdx_d;
    logic [NLAG-2:0]           hist_q, hist_d;
    logic [(NCH-1)*LAGW-1:0]   did_q, did_d;
    logic                      didValid_q, didValid_d;
    logic                      ovf_q, ovf_d;
    logic [NLAG-1:0]           tap;
    logic [LAGW-1:0]           laneBest [NCH-1];
    logic                      accEn, laneClear, scanEn;

    assign tap       = {hist_q, din[0]};
    assign accEn     = (state_q == ACCUM) && din_en;
    assign laneClear = (state_q == DONE);
    assign scanEn    = (state_q == SCAN);

    for (genvar k = 0; k < NCH - 1; k++) begin : g_lane
        ssl_corr_lane #(
            .NLAG (NLAG),
            .NWIN (NWIN)
        ) u_lane (
            .clk          (clk),
            .erst         (erst),
            .tap_i        (tap),
            .din_i        (din[k+1]),
            .acc_en_i     (accEn),
            .clear_i      (laneClear),
            .scan_en_i    (scanEn),
            .scan_idx_i   (scanIdx_q),
            .best_idx_d_o (laneBest[k])
        );
    end

    // The reference history shifts on every strobe regardless of state.
    always_comb begin
        hist_d = hist_q;
        if (din_en) begin
            hist_d[0] = din[0];
            for (int i = 1; i < NLAG - 1; i++) hist_d[i] = hist_q[i-1];
        end
    end

    always_comb begin
        state_d    = state_q;
        frameCnt_d = frameCnt_q;
        scanIdx_d  = scanIdx_q;
        did_d      = did_q;
        didValid_d = 1'b0;
        ovf_d      = ovf_q | (din_en && (state_q != ACCUM));
        case (state_q)
            ACCUM: begin
                if (din_en) begin
                    if (frameCnt_q == FCW'(NWIN - 1)) begin
                        frameCnt_d = '0;
                        state_d    = SCAN;
                    end else begin
                        frameCnt_d = frameCnt_q + FCW'(1);
                    end
                end
            end
            SCAN: begin
                if (scanIdx_q == LAGW'(NLAG - 1)) begin
                    // Lane next-values include the final index, so did is ready in DONE.
                    scanIdx_d  = '0;
                    state_d    = DONE;
                    didValid_d = 1'b1;
                    for (int k = 0; k < NCH - 1; k++) did_d[k*LAGW +: LAGW] = laneBest[k];
                end else begin
                    scanIdx_d = scanIdx_q + LAGW'(1);
                end
            end
            DONE:    state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge erst) begin
        if (!erst) begin
            state_q    <= ACCUM;
            frameCnt_q <= '0;
            scanIdx_q  <= '0;
            hist_q     <= '0;
            did_q      <= '0;
            didValid_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            frameCnt_q <= frameCnt_d;
            scanIdx_q  <= scanIdx_d;
            hist_q     <= hist_d;
            did_q      <= did_d;
            didValid_q <= didValid_d;
            ovf_q      <= ovf_d;
        end
    end

    assign did       = did_q;
    assign did_valid = didValid_q;
    assign busy      = (state_q != ACCUM);
    assign ovf       = ovf_q;

endmodule

// File: doc/ssl_xcorr.md
Name: ssl_xcorr

Overview:
- Parametrised successor of the 4-mic, 1-bit sound-source-localisation delay estimator.
- Channel 0 is the reference. For every other channel it accumulates 1-bit XNOR cross-correlation against the delayed reference over NLAG lags and a frame of NWIN samples.
- At frame end it scans the accumulators for the peak lag and publishes one delay index per channel, with a valid strobe.
- Adds over the previous generation: configurable channel count, sample-enable input, frame-based output with a valid pulse, a busy indication and sticky overrun detection.

Parameters:
- NCH, 4, number of 1-bit input channels; channel 0 is the reference; NCH >= 2.
- NLAG, 128, number of lags evaluated (0..NLAG-1); NLAG >= 2.
- NWIN, 1024, accepted samples per correlation frame; NWIN >= 2.
- Derived localparams: LAGW = $clog2(NLAG); ACCW = $clog2(NWIN+1); FCW = $clog2(NWIN).

Ports:
- clk  in  1  system clock, rising edge.
- erst  in  1  asynchronous, active-low reset.
- din  in  NCH  one sample bit per channel; din[0] is the reference.
- din_en  in  1  sample strobe; din is valid when high.
- did  out  (NCH-1)*LAGW  peak-lag index per channel; channel k occupies did[(k-1)*LAGW +: LAGW].
- did_valid  out  1  one-cycle pulse when did is updated.
- busy  out  1  high while not in ACCUM.
- ovf  out  1  sticky: a sample arrived while busy.

Behaviour:
- Reset (erst low, async): did=0, did_valid=0, busy=0, ovf=0; delay line, accumulators and frame counter cleared; state=ACCUM. Reset mid-frame discards the partial frame, and the next frame starts from zero.
- Delay line: NLAG-1 reference history bits. tap[0]=din[0]; tap[l] = the reference sample taken l accepted strobes earlier. The line shifts on every din_en in every state, so history stays continuous across SCAN and DONE.
- ACCUM:
  - On din_en, for each k in 1..NCH-1 and each l: acc[k][l] += (tap[l] XNOR din[k]). Frame counter increments.
  - ACCW is sized so the accumulators never overflow; no saturation logic is needed.
  - When din_en is high and the frame counter = NWIN-1: counter goes to 0, next state is SCAN.
- SCAN: NLAG cycles, idx = 0..NLAG-1.
  - Per channel, best value and best index are initialised from idx 0.
  - Update when acc[k][idx] is strictly greater than the best value, so ties resolve to the lowest lag.
  - Accumulators are frozen. din_en is dropped for correlation, the delay line still shifts, and ovf is set to 1.
- DONE: 1 cycle.
  - did is loaded with the best indices and did_valid=1.
  - Accumulators cleared; next state is ACCUM.
  - din_en here is also dropped and sets ovf.
- Latency: the last sample of a frame is accepted in cycle T; did_valid is high in cycle T+NLAG+1; ACCUM resumes in cycle T+NLAG+2.
- did holds its value between pulses. ovf clears only on reset. busy = (state != ACCUM).
- din_en low in ACCUM: nothing changes.

Decomposition:
- ssl_pkg holds:
  - state encoding: ACCUM, SCAN, DONE;
  - width helper functions for LAGW, ACCW and FCW.
- Sub-module ssl_corr_lane, instantiated NCH-1 times via generate. Each lane takes the shared tap vector and one channel bit and contains:
  - its NLAG accumulators;
  - the sequential argmax (best value and best index) driven by the shared scan index.
- Top level owns:
  - the FSM;
  - the frame counter and scan counter;
  - the delay line;
  - ovf.

Test Plan (NCH=4, NLAG=8, NWIN=64, din_en every other cycle unless stated):
- Reset: hold erst low 3 cycles with random din -> did=0, did_valid=0, busy=0, ovf=0; after release, first did_valid comes exactly 9 cycles after the 64th accepted sample.
- Known delays: ref = 10-bit LFSR; ch1 = ref delayed 3, ch2 = ref, ch3 = ref delayed 7 -> from frame 2 onward did = {3'd7, 3'd0, 3'd3}, with did_valid a single-cycle pulse.
- Tie-break: all din held 1 for 2 frames -> frame 2 has all acc=64 and did=0 for every channel.
- Overrun: din_en held high continuously -> ovf=1 from the first SCAN cycle and stays 1; frame 2 still reports correct delays (3, 0, 7); each frame accepts exactly 64 samples in ACCUM.
- Mid-frame reset: pull erst low after 30 accepted samples -> outputs cleared immediately; next did_valid comes only after 64 new samples plus 9 cycles.
- Frame-to-frame change: ch1 delay 2 during frame 2, then 5 during frames 3-4 -> ch1 field reads 2, then 5 from frame 4 (frame 3 may straddle the change); the value holds steady between pulses.
